display_multi_signal: RTL and testbench

//  Sequences several multi-digit hex signals onto one shared hex-digit drawer.
//  - Each signal is split into nibbles; nibbles are sent one at a time over a start/done handshake.
//  - Generalises single-signal nibble sequencing to SIGNALS signals of DIGITS digits each.
//  - Adds a snapshot of the input on start, a one-shot done pulse and a digit/row address to the drawer.
//  - Sits between the debug-signal taps and the hex drawer / frame-clear logic of the debug display.

---
 rtl/display_multi_signal.sv | 117 +++++++++++
 tb/tb_display_multi_signal.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/display_multi_signal.sv
// Sequences SIGNALS hex signals of DIGITS digits each, one nibble at a time, onto a shared hex drawer.
// Optional leading-zero blanking is built when DISPLAY_MULTI_SIGNAL_BLANK_EN is defined.
module display_multi_signal #(
   parameter int SIGNALS = 2,
   parameter int DIGITS  = 4,
   localparam int DATA_W = SIGNALS * DIGITS * 4,
   localparam int SEL_W  = (SIGNALS > 1) ? $clog2(SIGNALS) : 1,
   localparam int POS_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] signal_data,
   input  logic              start,
   input  logic              hex_done,
   output logic [3:0]        hex_data,
   output logic [SEL_W-1:0]  hex_sel,
   output logic [POS_W-1:0]  hex_pos,
   output logic              hex_start,
   output logic              hex_blank,
   output logic              clear_all,
   output logic              busy,
   output logic              done
);

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SIGNALS - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(DIGITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SEND,
      WAIT,
      FIN
   } state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [DATA_W-1:0]   snap_q, snap_d;
   logic [DIGITS*4-1:0] row;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         pos_q   <= '0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         pos_q   <= pos_d;
         snap_q  <= snap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      pos_d   = pos_q;
      snap_d  = snap_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               snap_d  = signal_data;
               sel_d   = '0;
               pos_d   = POS_LAST;
               state_d = CLEAR;
            end
         end
         CLEAR: state_d = SEND;
         SEND:  state_d = WAIT;
         WAIT: begin
            if (hex_done) begin
               if (pos_q != '0) begin
                  pos_d   = pos_q - POS_W'(1);
                  state_d = SEND;
               end else if (sel_q != SEL_LAST) begin
                  sel_d   = sel_q + SEL_W'(1);
                  pos_d   = POS_LAST;
                  state_d = SEND;
               end else begin
                  state_d = FIN;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      row       = snap_q[32'(sel_q) * DIGITS * 4 +: DIGITS * 4];
      hex_data  = row[32'(pos_q) * 4 +: 4];
      hex_sel   = sel_q;
      hex_pos   = pos_q;
      hex_start = (state_q == SEND);
      clear_all = (state_q == CLEAR);
      done      = (state_q == FIN);
      busy      = (state_q != IDLE);
   end

`ifdef DISPLAY_MULTI_SIGNAL_BLANK_EN
   logic lead_zero;

   // A digit is blank while it and every more-significant digit of its row are zero.
   always_comb begin
      lead_zero = 1'b1;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (d >= 32'(pos_q) && row[d*4 +: 4] != 4'h0) lead_zero = 1'b0;
      end
      hex_blank = (state_q == SEND || state_q == WAIT) && (pos_q != '0) && lead_zero;
   end
`else
   assign hex_blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_multi_signal.sv
// Scoreboard bench for display_multi_signal (SIGNALS=2, DIGITS=4); expected digits queued at start, checked on hex_start.
module tb_display_multi_signal;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] signal_data = '0;
   logic        start = 1'b0;
   logic        hex_done = 1'b1;
   logic [3:0]  hex_data;
   logic [0:0]  hex_sel;
   logic [1:0]  hex_pos;
   logic        hex_start, hex_blank, clear_all, busy, done;

   display_multi_signal #(.SIGNALS(2), .DIGITS(4)) dut (
      .clock(clock), .reset(reset), .signal_data(signal_data), .start(start),
      .hex_done(hex_done), .hex_data(hex_data), .hex_sel(hex_sel), .hex_pos(hex_pos),
      .hex_start(hex_start), .hex_blank(hex_blank), .clear_all(clear_all),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int d;
      int s;
      int p;
      int b;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   n_hs = 0;
   int   cur_exp_d = 0;
   bit   slow_mode = 1'b0;
   int   pend = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: signal 0 first, most-significant digit first, optional leading-zero blank.
   task automatic push_exp(input logic [31:0] data);
      exp_t e;
      logic [3:0] nib;
      bit z;
      for (int s = 0; s < 2; s++) begin
         for (int p = 3; p >= 0; p--) begin
            nib = data[s*16 + p*4 +: 4];
            z = 1'b1;
            for (int q = p; q < 4; q++) if (data[s*16 + q*4 +: 4] != 4'h0) z = 1'b0;
            e.d = int'(nib);
            e.s = s;
            e.p = p;
`ifdef DISPLAY_MULTI_SIGNAL_BLANK_EN
            e.b = (p > 0 && z) ? 1 : 0;
`else
            e.b = 0;
`endif
            exp_q.push_back(e);
         end
      end
   endtask

   // Monitor
   always @(negedge clock) begin
      exp_t e;
      if (hex_start) begin
         n_hs++;
         if (exp_q.size() == 0) begin
            check("unexpected_hex_start", 1, 0);
         end else begin
            e = exp_q.pop_front();
            cur_exp_d = e.d;
            check("hex_data", int'(hex_data), e.d);
            check("hex_sel", int'(hex_sel), e.s);
            check("hex_pos", int'(hex_pos), e.p);
            check("hex_blank", int'(hex_blank), e.b);
         end
      end
   end

   // Drawer model: tied-high done, or done 5 cycles after each hex_start.
   always @(negedge clock) begin
      if (!slow_mode) begin
         hex_done = 1'b1;
         pend = 0;
      end else begin
         hex_done = 1'b0;
         if (hex_start) begin
            pend = 5;
         end else if (pend > 0) begin
            check("hold_data", int'(hex_data), cur_exp_d);
            pend--;
            if (pend == 0) hex_done = 1'b1;
         end
      end
   end

   task automatic run_refresh(input logic [31:0] data, input bit zero_after,
                              input bit slow, input bit poke);
      int c;
      int n0;
      bit got;
      slow_mode = slow;
      push_exp(data);
      n0 = n_hs;
      @(negedge clock);
      signal_data = data;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      c = 1;
      if (zero_after) signal_data = '0;
      check("clear_all_at_1", int'(clear_all), 1);
      check("busy_at_1", int'(busy), 1);
      got = 1'b0;
      while (!got && c < 400) begin
         @(negedge clock);
         c++;
         if (poke) start = (c % 7 == 3) && (c < 40);
         if (done) got = 1'b1;
         else check("busy_during", int'(busy), 1);
      end
      start = 1'b0;
      if (!got) check("done_timeout", 0, 1);
      else if (!slow) check("done_cycle", c, 18);
      @(negedge clock);
      check("busy_after_done", int'(busy), 0);
      check("digit_count", n_hs - n0, 8);
      check("queue_drained", exp_q.size(), 0);
      slow_mode = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int c;
      int dones;
      // Reset and idle
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("idle_busy", int'(busy), 0);
         check("idle_hex_start", int'(hex_start), 0);
         check("idle_clear_all", int'(clear_all), 0);
         check("idle_done", int'(done), 0);
         check("idle_hex_blank", int'(hex_blank), 0);
      end

      run_refresh(32'h89AB_1234, 1'b0, 1'b0, 1'b0);
      run_refresh(32'h89AB_1234, 1'b1, 1'b0, 1'b0);
      run_refresh(32'h89AB_1234, 1'b0, 1'b1, 1'b1);

      // Reset after the 3rd hex_start, then a full replay
      push_exp(32'h89AB_1234);
      @(negedge clock);
      signal_data = 32'h89AB_1234;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      k = 0;
      c = 0;
      while (k < 3 && c < 100) begin
         if (hex_start) k++;
         if (k < 3) begin
            @(negedge clock);
            c++;
         end
      end
      check("third_hex_start_seen", k, 3);
      reset = 1'b1;
      @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_hex_start", int'(hex_start), 0);
      check("rst_clear_all", int'(clear_all), 0);
      check("rst_done", int'(done), 0);
      check("rst_hex_blank", int'(hex_blank), 0);
      reset = 1'b0;
      exp_q.delete();
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (done) dones++;
      end
      check("no_done_after_abort", dones, 0);
      run_refresh(32'h89AB_1234, 1'b0, 1'b0, 1'b0);

      run_refresh(32'h0000_00A0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
